la_sweep_checker: RTL and testbench



---
 rtl/la_sweep_checker.sv | 162 ++++++++++++++++
 tb/tb_la_sweep_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/la_sweep_checker.sv
// la_sweep_checker
//   Sweeps every (A, B, ci) operand vector through an external lookahead
//   adder. For each vector it measures how many cycles the adder output takes
//   to settle, counts vectors that never settle, and records the slowest one.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start           pulse to begin a sweep; only honoured in IDLE or DONE
//   A, B, ci        registered operands driven into the adder
//   sum_in, co_in   adder result fed back for checking
//   busy, done      sweep in progress / sweep finished (results held)
//   err_count       saturating count of timed-out vectors
//   first_err_*     operands of the first timed-out vector
//   max_lat, max_*  worst accepted settling latency and its operands
module la_sweep_checker #(
  parameter int N       = 8,
  parameter int STABLE  = 2,
  parameter int TIMEOUT = 255,
  parameter int LW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic          ci,
  input  logic [N-1:0]  sum_in,
  input  logic          co_in,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_count,
  output logic [N-1:0]  first_err_A,
  output logic [N-1:0]  first_err_B,
  output logic          first_err_ci,
  output logic [LW-1:0] max_lat,
  output logic [N-1:0]  max_A,
  output logic [N-1:0]  max_B,
  output logic          max_ci
);

  localparam logic [2:0] sIdle  = 3'd0;
  localparam logic [2:0] sApply = 3'd1;
  localparam logic [2:0] sWait  = 3'd2;
  localparam logic [2:0] sNext  = 3'd3;
  localparam logic [2:0] sDone  = 3'd4;

  logic [2:0]    state;
  logic [N:0]    expVal;
  logic [LW-1:0] lat;
  logic [3:0]    run;
  logic          accepted;
  logic [LW-1:0] latL;

  logic          match;
  logic [3:0]    runNext;
  logic          acceptNow;
  logic [LW-1:0] measL;
  logic          isLast;
  logic [2*N:0]  vecInc;

  // Expected adder result, computed one bit wider so carry-out is included.
  function automatic logic [N:0] calcExp(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic c);
    calcExp = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  assign match     = ({co_in, sum_in} == expVal);
  assign runNext   = match ? run + 4'd1 : 4'd0;
  assign acceptNow = (runNext == 4'(STABLE));
  // Latency is the WAIT index where the final matching run began.
  assign measL     = lat - LW'(STABLE - 1);
  assign isLast    = (&A) & (&B) & ci;
  // ci is the most significant digit, so B carries into A and A into ci.
  assign vecInc    = {ci, A, B} + {{(2*N){1'b0}}, 1'b1};

  assign busy = (state == sApply) || (state == sWait) || (state == sNext);
  assign done = (state == sDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= sIdle;
      A            <= '0;
      B            <= '0;
      ci           <= 1'b0;
      expVal       <= '0;
      lat          <= '0;
      run          <= '0;
      accepted     <= 1'b0;
      latL         <= '0;
      err_count    <= '0;
      first_err_A  <= '0;
      first_err_B  <= '0;
      first_err_ci <= 1'b0;
      max_lat      <= '0;
      max_A        <= '0;
      max_B        <= '0;
      max_ci       <= 1'b0;
    end else begin
      case (state)
        sIdle, sDone: begin
          if (start) begin
            A            <= '0;
            B            <= '0;
            ci           <= 1'b0;
            expVal       <= '0;
            err_count    <= '0;
            first_err_A  <= '0;
            first_err_B  <= '0;
            first_err_ci <= 1'b0;
            max_lat      <= '0;
            max_A        <= '0;
            max_B        <= '0;
            max_ci       <= 1'b0;
            state        <= sApply;
          end
        end
        sApply: begin
          lat      <= '0;
          run      <= '0;
          accepted <= 1'b0;
          state    <= sWait;
        end
        sWait: begin
          run <= runNext;
          lat <= lat + 1'b1;
          if (acceptNow) begin
            accepted <= 1'b1;
            latL     <= measL;
            state    <= sNext;
          end else if (lat == LW'(TIMEOUT - 1)) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) begin
              first_err_A  <= A;
              first_err_B  <= B;
              first_err_ci <= ci;
            end
            state <= sNext;
          end
        end
        sNext: begin
          // Strict compare keeps the earliest vector on ties.
          if (accepted && (latL > max_lat)) begin
            max_lat <= latL;
            max_A   <= A;
            max_B   <= B;
            max_ci  <= ci;
          end
          if (isLast) begin
            state <= sDone;
          end else begin
            {ci, A, B} <= vecInc;
            expVal     <= calcExp(vecInc[N-1:0], vecInc[2*N-1:N], vecInc[2*N]);
            state      <= sApply;
          end
        end
        default: state <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_la_sweep_checker.sv
module tb_la_sweep_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  A, B;
  logic        ci;
  logic [3:0]  sumIn;
  logic        coIn;
  logic        busy, done;
  logic [15:0] errCount;
  logic [3:0]  feA, feB;
  logic        feCi;
  logic [7:0]  maxLat;
  logic [3:0]  mxA, mxB;
  logic        mxCi;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  la_sweep_checker #(.N(4), .STABLE(2), .TIMEOUT(255), .LW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .ci(ci),
    .sum_in(sumIn), .co_in(coIn),
    .busy(busy), .done(done),
    .err_count(errCount),
    .first_err_A(feA), .first_err_B(feB), .first_err_ci(feCi),
    .max_lat(maxLat), .max_A(mxA), .max_B(mxB), .max_ci(mxCi)
  );

  // Adder model. age counts cycles since the operands last changed:
  // 0 in APPLY, k+1 in WAIT cycle k.
  //   mode 1: zero delay          mode 2: 3-cycle delay
  //   mode 3: 1 cycle, 5 for (F,1,1)   mode 4: wrong sum for (3,5,0)
  //   mode 5: glitch in WAIT cycle 1 for (2,2,0)
  int         mode = 1;
  int         age  = 0;
  logic [8:0] prevVec = 9'h1FF;

  always @(negedge clk) begin
    if ({ci, A, B} !== prevVec) age = 0;
    else if (age < 100000) age = age + 1;
    prevVec = {ci, A, B};
  end

  logic [4:0] good, modelOut;
  int         dly;
  logic       okNow;
  always_comb begin
    good = {1'b0, A} + {1'b0, B} + {4'b0, ci};
    dly  = 0;
    if (mode == 2) dly = 3;
    else if (mode == 3) dly = (A == 4'hF && B == 4'h1 && ci) ? 5 : 1;
    okNow = (age >= dly + 1);
    if (mode == 5 && A == 4'h2 && B == 4'h2 && !ci && age == 2) okNow = 1'b0;
    modelOut = okNow ? good : ~good;
    if (mode == 4 && A == 4'h3 && B == 4'h5 && !ci) modelOut = 5'h09;
  end
  assign sumIn = modelOut[3:0];
  assign coIn  = modelOut[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, then counts busy cycles until the sweep leaves busy.
  task automatic runSweep(output int cyc, output logic [8:0] firstVec);
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    firstVec = {ci, A, B};
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          mode;
    int          cycles;
    logic [15:0] err;
    logic [3:0]  fA, fB;
    logic        fCi;
    logic [7:0]  lat;
    logic [3:0]  mA, mB;
    logic        mCi;
  } scen_t;

  scen_t tbl[5];
  int cyc;
  logic [8:0] fv;

  initial begin
    tbl[0] = '{1, 2048, 16'd0, 4'h0, 4'h0, 1'b0, 8'd0, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{2, 3584, 16'd0, 4'h0, 4'h0, 1'b0, 8'd3, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{3, 2564, 16'd0, 4'h0, 4'h0, 1'b0, 8'd5, 4'hF, 4'h1, 1'b1};
    tbl[3] = '{4, 2301, 16'd1, 4'h3, 4'h5, 1'b0, 8'd0, 4'h0, 4'h0, 1'b0};
    tbl[4] = '{5, 2050, 16'd0, 4'h0, 4'h0, 1'b0, 8'd2, 4'h2, 4'h2, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_vec", 32'({ci, A, B}), 0);
    chk("reset_err", 32'(errCount), 0);
    chk("reset_maxlat", 32'(maxLat), 0);
    chk("reset_maxvec", 32'({mxCi, mxA, mxB}), 0);
    chk("reset_fevec", 32'({feCi, feA, feB}), 0);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      runSweep(cyc, fv);
      chk($sformatf("s%0d_firstvec", i + 1), 32'(fv), 0);
      chk($sformatf("s%0d_busycycles", i + 1), cyc, tbl[i].cycles);
      chk($sformatf("s%0d_done", i + 1), 32'(done), 1);
      chk($sformatf("s%0d_err", i + 1), 32'(errCount), 32'(tbl[i].err));
      chk($sformatf("s%0d_fevec", i + 1), 32'({feCi, feA, feB}),
          32'({tbl[i].fCi, tbl[i].fA, tbl[i].fB}));
      chk($sformatf("s%0d_maxlat", i + 1), 32'(maxLat), 32'(tbl[i].lat));
      chk($sformatf("s%0d_maxvec", i + 1), 32'({mxCi, mxA, mxB}),
          32'({tbl[i].mCi, tbl[i].mA, tbl[i].mB}));
      repeat (3) @(negedge clk);
      chk($sformatf("s%0d_done_held", i + 1), 32'({done, busy, maxLat}),
          32'({1'b1, 1'b0, tbl[i].lat}));
    end

    // Start while busy is ignored; then reset mid-sweep at A=7.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_vec", 32'({ci, A, B}), 32'h002);
    chk("start_ignored_busy", 32'(busy), 1);
    cyc = 0;
    while (A != 4'h7 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("reach_A7", 32'(A), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy_done", 32'({busy, done}), 0);
    chk("midrst_vec", 32'({ci, A, B}), 0);
    chk("midrst_stats", 32'({errCount, maxLat}), 0);
    chk("midrst_vecs2", 32'({feCi, feA, feB, mxCi, mxA, mxB}), 0);
    repeat (2) @(negedge clk);
    chk("midrst_idle", 32'({busy, done}), 0);
    runSweep(cyc, fv);
    chk("rerun_firstvec", 32'(fv), 0);
    chk("rerun_busycycles", cyc, 2048);
    chk("rerun_done", 32'(done), 1);
    chk("rerun_err", 32'(errCount), 0);
    chk("rerun_maxlat", 32'(maxLat), 0);
    chk("rerun_maxvec", 32'({mxCi, mxA, mxB}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
